serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_ctrl_if.sv | 41 ++++
 rtl/bit_full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 101 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder slice.
package serial_adder_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: start/done handshake, operands and result of the
// bit-serial adder. The ovf signal exists only when SERIAL_ADDER_OVERFLOW_EN
// is defined.
interface serial_adder_ctrl_if
    import serial_adder_pkg::*;
#(
    parameter int N = DEFAULT_N
);

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic [N-1:0] sum;
    logic         cout;
    logic         done;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic         ovf;
`endif

    // host side
    modport master (
`ifdef SERIAL_ADDER_OVERFLOW_EN
        input  ovf,
`endif
        output start, a, b, cin,
        input  ready, busy, sum, cout, done
    );

    // adder side
    modport slave (
`ifdef SERIAL_ADDER_OVERFLOW_EN
        output ovf,
`endif
        input  start, a, b, cin,
        output ready, busy, sum, cout, done
    );

endinterface

// File: rtl/bit_full_adder.sv
// bit_full_adder: purely combinational one-bit full adder.
module bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial N-bit adder. One full adder is reused over N
// cycles, LSB first, with a registered carry; sum bits shift in from the top.
// Optional macro SERIAL_ADDER_OVERFLOW_EN adds a registered signed-overflow
// flag (bus.ovf). The interface instance must use the same N as this module.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_ctrl_if.slave bus
);

    localparam int CW = $clog2(N + 1);

    state_t        state;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic          carry;
    logic [CW-1:0] count;
    logic          fa_s;
    logic          fa_co;
    logic [N-1:0]  sum_nxt;

    bit_full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // new sum bit enters at the MSB; a single-bit result is just the sum bit
    if (N == 1) begin : g_sum1
        assign sum_nxt = fa_s;
    end else begin : g_sumn
        assign sum_nxt = {fa_s, bus.sum[N-1:1]};
    end

    // controller FSM with all datapath and handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            carry     <= 1'b0;
            count     <= '0;
            bus.sum   <= '0;
            bus.cout  <= 1'b0;
            bus.done  <= 1'b0;
            bus.busy  <= 1'b0;
            bus.ready <= 1'b1;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            bus.ovf   <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr      <= bus.a;
                        b_sr      <= bus.b;
                        carry     <= bus.cin;
                        count     <= '0;
                        bus.ready <= 1'b0;
                        bus.busy  <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry   <= fa_co;
                    bus.sum <= sum_nxt;
                    count   <= count + 1'b1;
                    if (count == CW'(N - 1)) begin
                        bus.cout <= fa_co;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        // carry holds the carry into the MSB on the last bit
                        bus.ovf  <= carry ^ fa_co;
`endif
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    bus.ready <= 1'b1;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized and directed checks of serial_adder_ctrl
// against a transaction-level model (accept cycle, latency, a+b+cin).
// Honours SERIAL_ADDER_OVERFLOW_EN for the ovf output.
module tb_serial_adder_ctrl;
    import serial_adder_pkg::*;

    localparam int N = DEFAULT_N;

    logic clk = 1'b0;
    logic rst;

    // free-running clock
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.N(N)) bus ();

    serial_adder_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int         cyc     = 0;
    int         free_at = 0;
    int         acc_t   = -1;
    int         done_at = -1;
    bit         chk_en  = 1'b0;
    logic [N:0] res     = '0;
    logic [N:0] pend    = '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic       ovf_res  = 1'b0;
    logic       ovf_pend = 1'b0;

    function automatic logic signed_ovf(input logic [N-1:0] x, input logic [N-1:0] y,
                                        input logic c);
        int sx = int'(x);
        int sy = int'(y);
        int s;
        if (x[N-1]) sx -= (1 << N);
        if (y[N-1]) sy -= (1 << N);
        s = sx + sy + int'(c);
        return (s > (1 << (N - 1)) - 1) || (s < -(1 << (N - 1)));
    endfunction
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // check outputs of the current cycle, apply its inputs to the model, advance
    task automatic step();
        bit in_run_shift;
        if (chk_en) begin
            if (cyc == done_at) begin
                res = pend;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                ovf_res = ovf_pend;
`endif
            end
            in_run_shift = (acc_t >= 0) && (cyc >= acc_t + 2) && (cyc <= acc_t + N);
            chk("ready", bus.ready, 64'(cyc >= free_at));
            chk("busy", bus.busy, 64'((acc_t >= 0) && (cyc >= acc_t + 1) && (cyc <= acc_t + N)));
            chk("done", bus.done, 64'(cyc == done_at));
            if (!in_run_shift) begin
                chk("sum_hold", bus.sum, 64'(res[N-1:0]));
                chk("cout_hold", bus.cout, 64'(res[N]));
`ifdef SERIAL_ADDER_OVERFLOW_EN
                chk("ovf_hold", bus.ovf, 64'(ovf_res));
`endif
            end
        end
        if (rst) begin
            free_at = cyc + 1;
            acc_t   = -1;
            done_at = -1;
            res     = '0;
            chk_en  = 1'b1;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ovf_res = 1'b0;
`endif
        end else if (bus.start && cyc >= free_at) begin
            acc_t   = cyc;
            free_at = cyc + N + 2;
            done_at = cyc + N + 1;
            pend    = (N+1)'(bus.a) + (N+1)'(bus.b) + (N+1)'(bus.cin);
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ovf_pend = signed_ovf(bus.a, bus.b, bus.cin);
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // one addition from an idle controller, leaving the bench at cycle t+N+2
    task automatic op(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        bus.cin   = c;
        step();
        bus.start = 1'b0;
        bus.a     = N'($urandom);
        bus.b     = N'($urandom);
        bus.cin   = 1'($urandom);
        repeat (N + 1) step();
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        chk("rst_ready", bus.ready, 1);
        chk("rst_sum", bus.sum, 0);
        chk("rst_done", bus.done, 0);
        step();

        op(8'h5A, 8'h3C, 1'b0);
        chk("sum_5a_3c", bus.sum, 64'h96);
        chk("cout_5a_3c", bus.cout, 0);

        op(8'hFF, 8'h01, 1'b0);
        chk("sum_ff_01", bus.sum, 64'h00);
        chk("cout_ff_01", bus.cout, 1);

        op(8'hFF, 8'h00, 1'b1);
        chk("sum_ff_00_c", bus.sum, 64'h00);
        chk("cout_ff_00_c", bus.cout, 1);

        // start during RUN must be ignored
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
        step();
        bus.start = 1'b0;
        repeat (2) step();
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
        step();
        bus.start = 1'b0;
        repeat (N - 2) step();
        chk("sum_ignore", bus.sum, 64'h30);
        chk("cout_ignore", bus.cout, 0);
        step();
        chk("ready_back", bus.ready, 1);
        step();

        // reset in the middle of RUN
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b0;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_ready", bus.ready, 1);
        chk("midrst_sum", bus.sum, 0);
        chk("midrst_cout", bus.cout, 0);
        repeat (N + 2) step();
        op(8'h01, 8'h01, 1'b0);
        chk("sum_01_01", bus.sum, 64'h02);

`ifdef SERIAL_ADDER_OVERFLOW_EN
        op(8'h7F, 8'h01, 1'b0);
        chk("sum_7f_01", bus.sum, 64'h80);
        chk("ovf_7f_01", bus.ovf, 1);
        chk("cout_7f_01", bus.cout, 0);
        op(8'hFF, 8'h01, 1'b0);
        chk("ovf_ff_01", bus.ovf, 0);
        chk("cout_ff_01b", bus.cout, 1);
`endif

        // back-to-back with start held high, fresh random operands every cycle
        bus.start = 1'b1;
        repeat (1000 * (N + 2)) begin
            bus.a   = N'($urandom);
            bus.b   = N'($urandom);
            bus.cin = 1'($urandom);
            step();
        end
        bus.start = 1'b0;
        repeat (N + 3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
